// File: rtl/bus_map_pkg.sv
// -----------------------------------------------------------------------------
// bus_map_pkg
//
// Shared definitions for the CPU bus region decoder: default address and
// region counts, the default memory map (ROM, IO, graphics, RAM) with
// per-region wait states, the region index enum and the decoder state enum.
//
// Packed map arrays are indexed by region number. Element 0 is the rightmost
// item of each concatenation.
// -----------------------------------------------------------------------------
package bus_map_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int NUM_REGIONS_DEF = 4;
    localparam int WAIT_W_DEF      = 4;

    // Region numbering used by the default map.
    typedef enum logic [1:0] {
        REGION_ROM = 2'd0,
        REGION_IO  = 2'd1,
        REGION_GFX = 2'd2,
        REGION_RAM = 2'd3
    } region_idx_t;

    // Inclusive start addresses:      RAM            GFX            IO             ROM
    localparam logic [NUM_REGIONS_DEF-1:0][ADDR_W_DEF-1:0] REGION_BASE_DEF =
        {32'h0800_0000, 32'h0401_0000, 32'h0400_0000, 32'h0000_0000};

    // Inclusive end addresses:        RAM            GFX            IO             ROM
    localparam logic [NUM_REGIONS_DEF-1:0][ADDR_W_DEF-1:0] REGION_LIMIT_DEF =
        {32'h0BFF_FFFF, 32'h0401_000F, 32'h0400_FFFF, 32'h0000_0FFF};

    // Wait cycles before the acknowledge:  RAM   GFX   IO    ROM
    localparam logic [NUM_REGIONS_DEF-1:0][WAIT_W_DEF-1:0] REGION_WAIT_DEF =
        {4'd1, 4'd2, 4'd1, 4'd0};

    // Decoder transaction states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } decode_state_t;

endpackage : bus_map_pkg

// File: rtl/region_match.sv
// -----------------------------------------------------------------------------
// region_match
//
// Combinational range compare of one address against every region's
// [base, limit] window. Compares are unsigned and inclusive on both bounds.
// When windows overlap the lowest region index wins, so match is always
// one-hot or zero.
//
// Ports:
//   address  in   ADDR_W       address under test
//   hit      out  1            address falls inside at least one region
//   match    out  NUM_REGIONS  one-hot select of the lowest matching region
// -----------------------------------------------------------------------------
module region_match
    import bus_map_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_REGIONS = NUM_REGIONS_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE  = REGION_BASE_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_LIMIT = REGION_LIMIT_DEF
) (
    input  logic [ADDR_W-1:0]      address,
    output logic                   hit,
    output logic [NUM_REGIONS-1:0] match
);

    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        hit   = 1'b0;
        match = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            // Offset-from-base compare: an address below base wraps to a large
            // offset and fails, so one subtraction covers both bounds. This
            // relies on every limit being >= its base.
            if (!hit &&
                ((address - REGION_BASE[i]) <= (REGION_LIMIT[i] - REGION_BASE[i]))) begin
                match[i] = 1'b1;
                hit      = 1'b1;
            end
        end
    end

endmodule : region_match

// File: rtl/bus_region_decoder.sv
// -----------------------------------------------------------------------------
// bus_region_decoder
//
// Registered CPU bus address decoder. An accepted request is decoded into a
// one-hot region select held for the whole transaction, followed after the
// region's programmed wait states by a one-cycle acknowledge. Unmapped
// addresses produce a one-cycle bus error instead. Requests are accepted only
// in IDLE, so there is at least one idle cycle between transactions.
//
// Optional feature (macro ADDR_DECODE_FAULT_CAPTURE_EN): captures the address
// of the first unmapped access into Fault_Addr and raises a sticky
// Fault_Valid_H, cleared by Fault_Clr_H. Without the macro, the fault outputs
// are tied to zero and Fault_Clr_H is ignored; the ports remain present.
//
// Ports:
//   Clock          in   1            rising-edge clock
//   Reset_L        in   1            asynchronous active-low reset
//   Address        in   ADDR_W       request address, used at acceptance
//   Req_H          in   1            request valid (level)
//   Busy_H         out  1            transaction in progress
//   Select_H       out  NUM_REGIONS  one-hot registered region select
//   Ack_H          out  1            one-cycle completion pulse
//   Err_H          out  1            one-cycle unmapped-address pulse
//   Fault_Addr     out  ADDR_W       first captured faulting address
//   Fault_Valid_H  out  1            sticky fault flag
//   Fault_Clr_H    in   1            clears Fault_Valid_H on the next edge
// -----------------------------------------------------------------------------
module bus_region_decoder
    import bus_map_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_REGIONS = NUM_REGIONS_DEF,
    parameter int WAIT_W      = WAIT_W_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE  = REGION_BASE_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_LIMIT = REGION_LIMIT_DEF,
    parameter logic [NUM_REGIONS-1:0][WAIT_W-1:0] REGION_WAIT  = REGION_WAIT_DEF
) (
    input  logic                   Clock,
    input  logic                   Reset_L,
    input  logic [ADDR_W-1:0]      Address,
    input  logic                   Req_H,
    output logic                   Busy_H,
    output logic [NUM_REGIONS-1:0] Select_H,
    output logic                   Ack_H,
    output logic                   Err_H,
    output logic [ADDR_W-1:0]      Fault_Addr,
    output logic                   Fault_Valid_H,
    input  logic                   Fault_Clr_H
);

    decode_state_t            state_q, state_d;
    logic [WAIT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REGIONS-1:0]   sel_q, sel_d;

    logic                     hit;
    logic [NUM_REGIONS-1:0]   match;
    logic [WAIT_W-1:0]        wait_sel;

    // The address only matters at the acceptance edge: the decode result is
    // captured into sel_q/cnt_q, so later address changes have no effect.
    region_match #(
        .ADDR_W       (ADDR_W),
        .NUM_REGIONS  (NUM_REGIONS),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT)
    ) u_region_match (
        .address (Address),
        .hit     (hit),
        .match   (match)
    );

    // Wait count of the matched region (match is one-hot or zero).
    always_comb begin
        wait_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (match[i]) begin
                wait_sel = REGION_WAIT[i];
            end
        end
    end

    // Next-state, counter and select logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (Req_H) begin
                    if (hit) begin
                        sel_d = match;
                        if (wait_sel == '0) begin
                            state_d = ACK;
                        end else begin
                            cnt_d   = wait_sel;
                            state_d = WAIT;
                        end
                    end else begin
                        sel_d   = '0;
                        state_d = ERR;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                // <= rather than == so a zero count can never stall the FSM.
                if (cnt_q <= WAIT_W'(1)) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            ERR: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Outputs are decoded straight from registered state, so they are glitch
    // free and Ack_H/Err_H are mutually exclusive by construction.
    assign Busy_H   = (state_q != IDLE);
    assign Ack_H    = (state_q == ACK);
    assign Err_H    = (state_q == ERR);
    assign Select_H = sel_q;

`ifdef ADDR_DECODE_FAULT_CAPTURE_EN
    logic [ADDR_W-1:0] fault_addr_q;
    logic              fault_valid_q;
    logic              enter_err;

    // Same condition that moves the FSM from IDLE into ERR.
    assign enter_err = (state_q == IDLE) && Req_H && !hit;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            fault_addr_q  <= '0;
            fault_valid_q <= 1'b0;
        end else if (Fault_Clr_H) begin
            // Clear wins over a fault arriving on the same edge; that fault
            // is dropped. The stored address is kept for post-mortem reads.
            fault_valid_q <= 1'b0;
        end else if (enter_err && !fault_valid_q) begin
            fault_addr_q  <= Address;
            fault_valid_q <= 1'b1;
        end
    end

    assign Fault_Addr    = fault_addr_q;
    assign Fault_Valid_H = fault_valid_q;
`else
    logic unused_fault_clr;

    assign Fault_Addr       = '0;
    assign Fault_Valid_H    = 1'b0;
    assign unused_fault_clr = Fault_Clr_H;
`endif

endmodule : bus_region_decoder

// File: doc/bus_region_decoder.md
Name: bus_region_decoder

Overview:
- Parametrised, registered successor to the combinational address decoder.
- Decodes a CPU bus request into one of NUM_REGIONS one-hot region selects, with per-region programmable wait states.
- Returns a single-cycle acknowledge, or a bus error for unmapped addresses.
- Sits between the RISC-V core's data/instruction bus and the ROM, IO, graphics and RAM slaves.

Parameters:
- ADDR_W, 32: address width.
- NUM_REGIONS, 4: number of decoded regions.
- WAIT_W, 4: width of each wait-state count.
- REGION_BASE, pkg default {0x00000000, 0x04000000, 0x04010000, 0x08000000}: inclusive region start addresses.
- REGION_LIMIT, pkg default {0x00000FFF, 0x0400FFFF, 0x0401000F, 0x0BFFFFFF}: inclusive region end addresses.
- REGION_WAIT, pkg default {0, 1, 2, 1}: wait cycles before Ack_H, per region.

Ports:
- Clock, in, 1: sole clock, rising edge.
- Reset_L, in, 1: asynchronous, active-low reset.
- Address, in, ADDR_W: request address, sampled on acceptance.
- Req_H, in, 1: request valid (level).
- Busy_H, out, 1: transaction in progress; Req_H ignored while high.
- Select_H, out, NUM_REGIONS: one-hot registered region select.
- Ack_H, out, 1: one-cycle completion pulse.
- Err_H, out, 1: one-cycle unmapped-address pulse.
- Fault_Addr, out, ADDR_W: captured faulting address (optional feature).
- Fault_Valid_H, out, 1: sticky fault flag (optional feature).
- Fault_Clr_H, in, 1: clears the fault flag (optional feature).

Behaviour:
- Reset (Reset_L low, asynchronous):
  - State goes to IDLE.
  - Select_H, Ack_H, Err_H, Busy_H, Fault_Addr and Fault_Valid_H all go to 0.
  - Counter is cleared.
  - Asserting reset mid-transaction aborts it with no Ack_H or Err_H.
- States: IDLE, WAIT, ACK, ERR.
- IDLE:
  - If Req_H is high at edge T, latch Address and decode it.
  - Hit region i (lowest index wins on overlap): Select_H[i]=1 and Busy_H=1 from T+1.
    - REGION_WAIT[i]=0: go to ACK.
    - Otherwise: load counter with REGION_WAIT[i] and go to WAIT.
  - Miss: go to ERR with Busy_H=1 and Select_H=0.
- WAIT: decrement counter each cycle; when counter==1, next state is ACK.
- ACK:
  - Ack_H=1 for exactly one cycle; Select_H is still held.
  - Next state is IDLE, with Select_H, Busy_H and Ack_H cleared.
- Latency: Ack_H is high during cycle T+1+REGION_WAIT[i].
- ERR: Err_H=1 for one cycle, then IDLE.
- Back-to-back requests:
  - Req_H held high is re-accepted on the first IDLE edge, i.e. the cycle after ACK/ERR.
  - There is therefore at least one idle cycle between transactions.
- Address changes while Busy_H is high have no effect (address is latched).
- Range compares are unsigned and inclusive on both bounds.
- Address at REGION_LIMIT+1 misses unless another region covers it.
- Ack_H and Err_H are never high together.
- Select_H is one-hot or zero at all times.

Optional Feature:
- Macro: ADDR_DECODE_FAULT_CAPTURE_EN.
- Defined:
  - On entry to ERR, Fault_Addr takes the latched address and Fault_Valid_H sets.
  - Only the first fault is captured while Fault_Valid_H is high.
  - Fault_Clr_H high clears Fault_Valid_H on the next edge.
  - Clear has priority over a simultaneous new fault; that fault is lost.
- Undefined:
  - Fault_Addr and Fault_Valid_H are tied to 0; Fault_Clr_H is ignored.
  - Ports remain present.

Decomposition:
- Package bus_map_pkg holds:
  - ADDR_W_DEF.
  - NUM_REGIONS_DEF.
  - Region base/limit/wait constant arrays.
  - Region index enum: REGION_ROM, REGION_IO, REGION_GFX, REGION_RAM.
  - State enum typedef decode_state_t.
- One sub-module: region_match, a combinational compare of address against base/limit arrays giving hit and lowest-index one-hot match.
- FSM, counter and fault-capture logic live in bus_region_decoder.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: reset, Address=0x04010004, Req_H pulse, Reset_L low at T+2.
  - Response: all outputs 0 immediately, no Ack_H, IDLE after release.
- ROM, zero wait:
  - Stimulus: Address=0x00000FFF, Req_H high at T.
  - Response: Select_H=0001 from T+1, Ack_H at T+1, Busy_H low at T+2.
- Graphics, two waits:
  - Stimulus: Address=0x04010004.
  - Response: Select_H=0100 for T+1..T+3, Ack_H only at T+3.
- Unmapped addresses:
  - Stimulus: Address=0x00001000, then 0x0C000000.
  - Response: Err_H pulse at T+1, Select_H=0, no Ack_H.
  - With ADDR_DECODE_FAULT_CAPTURE_EN: Fault_Addr=0x00001000 after both faults (first kept); Fault_Clr_H clears the flag.
- Back-to-back:
  - Stimulus: Req_H held high; Address=0x08000000, changed to 0x04000000 while Busy_H.
  - Response: RAM Ack_H at T+2 with Select_H unchanged; IO select at T+4, Ack_H at T+5.
